quote_feed_tx: RTL and testbench
================================

Name: quote_feed_tx

Overview:
- Transmit side of the per-stock best-bid/best-ask feed that the volatility unit consumes (stock_id, data_valid, best_ask, best_bid).
- Accepts single-sided top-of-book price updates from the order book and keeps a shadow bid/ask per stock.
- Emits one coalesced, uncrossed quote per cycle, selecting among stocks with pending changes round-robin. A ready handshake supports backpressure; i_ready is tied high where the consumer has none.

Parameters:
DATA_WIDTH, 32, price width
NUM_STOCKS, 4, number of tracked stocks
CNT_WIDTH, 16, width of crossed-book event counter

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_book_valid  in  1  book update strobe
i_book_stock_id  in  $clog2(NUM_STOCKS)  stock of update
i_book_side  in  1  0 = bid, 1 = ask
i_book_price  in  DATA_WIDTH  new best price for that side
i_ready  in  1  downstream accepts quote
o_stock_id  out  $clog2(NUM_STOCKS)  stock of emitted quote
o_best_bid  out  DATA_WIDTH  emitted best bid
o_best_ask  out  DATA_WIDTH  emitted best ask
o_data_valid  out  1  quote valid
o_crossed_count  out  CNT_WIDTH  saturating count of crossed updates

Behaviour:
- Clock is i_clk. Reset is synchronous and active-high on i_reset; everything is sampled on the rising edge of i_clk.
- Reset state: o_data_valid=0, o_stock_id=0, o_best_bid=0, o_best_ask=0, o_crossed_count=0. All shadow bid/ask=0, seen_bid/seen_ask=0, dirty=0. The RR pointer is set to NUM_STOCKS-1 so that stock 0 has first priority.
- Reset takes priority over all other inputs. Reset asserted while a stalled quote is pending drops that quote: o_data_valid is 0 in the following cycle.
- Book update when i_book_valid=1 and stock id < NUM_STOCKS:
  - Write the price to the addressed side's shadow and set that side's seen flag.
  - Set dirty[id].
  - An id >= NUM_STOCKS is ignored.
- Crossed check: evaluated on the post-update shadow of the updated stock. If both sides are seen and bid >= ask, o_crossed_count increments by 1, saturating at all-ones. The count is once per offending update.
- Eligibility: eligible[s] = dirty[s] & seen_bid[s] & seen_ask[s] & (bid[s] < ask[s]).
  - A crossed stock keeps dirty set and becomes eligible again once an update uncrosses it.
- Arbitration:
  - Search starts at pointer+1 and wraps modulo NUM_STOCKS.
  - The first eligible stock is the grant. The pointer updates to the granted stock only on a load.
- Output register load condition: (!o_data_valid || i_ready) and a grant exists.
  - On load: o_stock_id, o_best_bid and o_best_ask take the granted stock's shadow as registered before this cycle's update. o_data_valid=1, and dirty[grant] clears.
  - Same-cycle book update to the granted stock: set wins, so dirty stays 1 and the new values emit later.
  - (!o_data_valid || i_ready) with no grant: o_data_valid goes to 0.
  - o_data_valid && !i_ready: all outputs hold stable, with no load and no dirty clear.
- Handshake: a transfer occurs in a cycle with o_data_valid && i_ready. Valid never drops without a transfer except on reset.
- Latency: an update sampled at edge of cycle t appears as o_data_valid in cycle t+2, provided the stock is the sole eligible one and the output is free.
- Coalescing: multiple updates to one stock before its grant produce a single quote carrying the latest values.
- Throughput: one quote per cycle with i_ready held high.
- Prices are unsigned. Comparisons are unsigned, with no arithmetic on prices.

Test Plan:
- Reset; stock 1 bid=100 only -> no o_data_valid for 10 cycles. Then stock 1 ask=105 at cycle t -> cycle t+2: o_data_valid=1, id=1, bid=100, ask=105, and a single pulse with i_ready=1.
- Stocks 2 and 0 both made eligible in the same cycle, i_ready=1 -> quotes id 0 then id 2 in consecutive cycles. A following update to stock 0 with stock 3 eligible: pointer is at 2, so stock 3 is emitted before stock 0.
- i_ready=0 for 4 cycles with quote (id 0, 100/105) pending; meanwhile stock 0 bid 101 then 102 -> outputs stay stable throughout the stall. After release: the 100/105 transfer, then exactly one quote with 102/105.
- Stock 3 bid=200, ask=150 -> no quote, o_crossed_count=1. Bid=140 -> o_crossed_count stays 1, and quote id 3, 140/150 is emitted 2 cycles later.
- Stock 1 granted in the same cycle as an update bid=110 to stock 1 -> old quote emitted, then a second quote with bid 110.
- i_reset asserted mid-stall with o_data_valid=1 -> next cycle o_data_valid=0 and counter=0. A single-sided update after reset emits nothing.

Source files
------------

// File: rtl/quote_feed_tx.sv
`default_nettype none
// ============================================================================
// quote_feed_tx : per-stock shadow bid/ask with round-robin coalesced quote out
// Rev 1.0
// ============================================================================
module quote_feed_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_STOCKS = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_book_valid,
    input  logic [$clog2(NUM_STOCKS)-1:0] i_book_stock_id,
    input  logic                          i_book_side,
    input  logic [DATA_WIDTH-1:0]         i_book_price,
    input  logic                          i_ready,
    output logic [$clog2(NUM_STOCKS)-1:0] o_stock_id,
    output logic [DATA_WIDTH-1:0]         o_best_bid,
    output logic [DATA_WIDTH-1:0]         o_best_ask,
    output logic                          o_data_valid,
    output logic [CNT_WIDTH-1:0]          o_crossed_count
);

    localparam int             ID_W        = $clog2(NUM_STOCKS);
    localparam logic [ID_W:0]  STOCK_LIMIT = (ID_W+1)'(NUM_STOCKS);

    logic [DATA_WIDTH-1:0] bid [NUM_STOCKS];
    logic [DATA_WIDTH-1:0] ask [NUM_STOCKS];
    logic [NUM_STOCKS-1:0] seen_bid;
    logic [NUM_STOCKS-1:0] seen_ask;
    logic [NUM_STOCKS-1:0] dirty;
    logic [NUM_STOCKS-1:0] eligible;
    logic [ID_W-1:0]       ptr;

    logic                  upd_ok;
    logic [DATA_WIDTH-1:0] new_bid;
    logic [DATA_WIDTH-1:0] new_ask;
    logic                  new_seen_bid;
    logic                  new_seen_ask;
    logic                  crossed;

    logic                  grant_valid;
    logic [ID_W-1:0]       grant_id;
    logic [ID_W:0]         sum;
    logic [ID_W-1:0]       idx;
    logic                  out_free;
    logic                  load;

    // Crossed detection looks at the book as it will be after this update.
    always_comb begin
        upd_ok       = i_book_valid && ({1'b0, i_book_stock_id} < STOCK_LIMIT);
        new_bid      = bid[i_book_stock_id];
        new_ask      = ask[i_book_stock_id];
        new_seen_bid = seen_bid[i_book_stock_id];
        new_seen_ask = seen_ask[i_book_stock_id];
        if (i_book_side) begin
            new_ask      = i_book_price;
            new_seen_ask = 1'b1;
        end else begin
            new_bid      = i_book_price;
            new_seen_bid = 1'b1;
        end
        crossed = upd_ok && new_seen_bid && new_seen_ask && (new_bid >= new_ask);
    end

    for (genvar s = 0; s < NUM_STOCKS; s++) begin : g_elig
        assign eligible[s] = dirty[s] & seen_bid[s] & seen_ask[s] & (bid[s] < ask[s]);
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        sum         = '0;
        idx         = '0;
        for (int k = 1; k <= NUM_STOCKS; k++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= STOCK_LIMIT) begin
                sum = sum - STOCK_LIMIT;
            end
            idx = sum[ID_W-1:0];
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_id    = idx;
            end
        end
    end

    assign out_free = !o_data_valid || i_ready;
    assign load     = out_free && grant_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int s = 0; s < NUM_STOCKS; s++) begin
                bid[s] <= '0;
                ask[s] <= '0;
            end
            seen_bid        <= '0;
            seen_ask        <= '0;
            dirty           <= '0;
            ptr             <= ID_W'(NUM_STOCKS - 1);
            o_stock_id      <= '0;
            o_best_bid      <= '0;
            o_best_ask      <= '0;
            o_data_valid    <= 1'b0;
            o_crossed_count <= '0;
        end else begin
            if (load) begin
                o_stock_id      <= grant_id;
                o_best_bid      <= bid[grant_id];
                o_best_ask      <= ask[grant_id];
                o_data_valid    <= 1'b1;
                ptr             <= grant_id;
                dirty[grant_id] <= 1'b0;
            end else if (out_free) begin
                o_data_valid <= 1'b0;
            end
            // Placed after the grant clear so a same-cycle update keeps the stock dirty.
            if (upd_ok) begin
                if (i_book_side) begin
                    ask[i_book_stock_id]      <= i_book_price;
                    seen_ask[i_book_stock_id] <= 1'b1;
                end else begin
                    bid[i_book_stock_id]      <= i_book_price;
                    seen_bid[i_book_stock_id] <= 1'b1;
                end
                dirty[i_book_stock_id] <= 1'b1;
            end
            if (crossed && !(&o_crossed_count)) begin
                o_crossed_count <= o_crossed_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_quote_feed_tx.sv
`default_nettype none
// Testbench for quote_feed_tx: scoreboard of expected quotes popped on each transfer.
module tb_quote_feed_tx;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] bid;
        logic [31:0] ask;
    } quote_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        book_valid;
    logic [1:0]  book_id;
    logic        book_side;
    logic [31:0] book_price;
    logic        ready;
    logic [1:0]  stock_id;
    logic [31:0] best_bid;
    logic [31:0] best_ask;
    logic        data_valid;
    logic [15:0] crossed_count;

    quote_t exp_q[$];
    quote_t mon_exp;
    quote_t got;
    int     n_checks = 0;
    int     n_fail   = 0;

    always #5 clk = ~clk;

    quote_feed_tx #(.DATA_WIDTH(32), .NUM_STOCKS(4), .CNT_WIDTH(16)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_book_valid    (book_valid),
        .i_book_stock_id (book_id),
        .i_book_side     (book_side),
        .i_book_price    (book_price),
        .i_ready         (ready),
        .o_stock_id      (stock_id),
        .o_best_bid      (best_bid),
        .o_best_ask      (best_ask),
        .o_data_valid    (data_valid),
        .o_crossed_count (crossed_count)
    );

    assign got = {stock_id, best_bid, best_ask};

    // Scoreboard: every transfer must match the oldest expected quote.
    always @(negedge clk) begin
        if (!reset && data_valid && ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_quote: got id=%0d bid=%0d ask=%0d, expected no quote",
                         stock_id, best_bid, best_ask);
            end else begin
                mon_exp = exp_q.pop_front();
                if (got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL quote_data: got id=%0d bid=%0d ask=%0d, expected id=%0d bid=%0d ask=%0d",
                             stock_id, best_bid, best_ask, mon_exp.id, mon_exp.bid, mon_exp.ask);
                end
            end
        end
    end

    function automatic quote_t mkq(input logic [1:0] i, input logic [31:0] b, input logic [31:0] a);
        return {i, b, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic book(input logic [1:0] id, input logic side, input logic [31:0] price);
        book_valid = 1'b1;
        book_id    = id;
        book_side  = side;
        book_price = price;
        tick();
        book_valid = 1'b0;
    endtask

    task automatic wait_drain(output int left);
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        left = exp_q.size();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({data_valid, stock_id, best_bid, best_ask, crossed_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%0b id=%0d bid=%0d ask=%0d cnt=%0d, expected all zero",
                     data_valid, stock_id, best_bid, best_ask, crossed_count);
        end
    endtask

    task automatic test_latency();
        book(2'd1, 1'b0, 32'd100);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (data_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL one_sided_quiet: got valid=%0b, expected 0 (cycle %0d)", data_valid, i);
            end
            tick();
        end
        exp_q.push_back(mkq(2'd1, 32'd100, 32'd105));
        book(2'd1, 1'b1, 32'd105);
        tick();
        n_checks++;
        if ({data_valid, stock_id} !== {1'b1, 2'd1}) begin
            n_fail++;
            $display("FAIL latency_t2: got valid=%0b id=%0d, expected valid=1 id=1", data_valid, stock_id);
        end
        tick();
        n_checks++;
        if (data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse: got valid=%0b, expected 0", data_valid);
        end
    endtask

    task automatic test_round_robin();
        int left;
        ready = 1'b0;
        exp_q.push_back(mkq(2'd3, 32'd300, 32'd310));
        book(2'd3, 1'b0, 32'd300);
        book(2'd3, 1'b1, 32'd310);
        exp_q.push_back(mkq(2'd0, 32'd10, 32'd20));
        exp_q.push_back(mkq(2'd2, 32'd50, 32'd60));
        book(2'd2, 1'b0, 32'd50);
        book(2'd2, 1'b1, 32'd60);
        book(2'd0, 1'b0, 32'd10);
        book(2'd0, 1'b1, 32'd20);
        ready = 1'b1;
        tick();
        n_checks++;
        if ({data_valid, stock_id} !== {1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL rr_first: got valid=%0b id=%0d, expected valid=1 id=0", data_valid, stock_id);
        end
        tick();
        n_checks++;
        if ({data_valid, stock_id} !== {1'b1, 2'd2}) begin
            n_fail++;
            $display("FAIL rr_second: got valid=%0b id=%0d, expected valid=1 id=2", data_valid, stock_id);
        end
        ready = 1'b0;
        exp_q.push_back(mkq(2'd3, 32'd302, 32'd310));
        exp_q.push_back(mkq(2'd0, 32'd12, 32'd20));
        book(2'd3, 1'b0, 32'd302);
        book(2'd0, 1'b0, 32'd12);
        ready = 1'b1;
        wait_drain(left);
        n_checks++;
        if (left != 0) begin
            n_fail++;
            $display("FAIL rr_drain: got %0d quotes outstanding, expected 0", left);
        end
    endtask

    task automatic test_stall();
        int left;
        quote_t held;
        do_reset();
        book(2'd0, 1'b0, 32'd100);
        ready = 1'b0;
        exp_q.push_back(mkq(2'd0, 32'd100, 32'd105));
        book(2'd0, 1'b1, 32'd105);
        tick();
        held = mkq(2'd0, 32'd100, 32'd105);
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if ({data_valid, got} !== {1'b1, held}) begin
                n_fail++;
                $display("FAIL stall_stable: got v=%0b id=%0d bid=%0d ask=%0d, expected v=1 id=0 bid=100 ask=105 (cycle %0d)",
                         data_valid, stock_id, best_bid, best_ask, c);
            end
            if (c == 0) book(2'd0, 1'b0, 32'd101);
            else if (c == 1) book(2'd0, 1'b0, 32'd102);
            else tick();
        end
        exp_q.push_back(mkq(2'd0, 32'd102, 32'd105));
        ready = 1'b1;
        wait_drain(left);
        n_checks++;
        if (left != 0) begin
            n_fail++;
            $display("FAIL stall_drain: got %0d quotes outstanding, expected 0", left);
        end
        tick();
        n_checks++;
        if (data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_coalesce: got valid=%0b, expected 0 after one coalesced quote", data_valid);
        end
    endtask

    task automatic test_crossed();
        int left;
        book(2'd3, 1'b0, 32'd200);
        book(2'd3, 1'b1, 32'd150);
        n_checks++;
        if (crossed_count !== 16'd1) begin
            n_fail++;
            $display("FAIL crossed_count: got %0d, expected 1", crossed_count);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (data_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL crossed_quiet: got valid=%0b, expected 0", data_valid);
            end
        end
        exp_q.push_back(mkq(2'd3, 32'd140, 32'd150));
        book(2'd3, 1'b0, 32'd140);
        n_checks++;
        if (crossed_count !== 16'd1) begin
            n_fail++;
            $display("FAIL uncross_count: got %0d, expected 1", crossed_count);
        end
        tick();
        n_checks++;
        if ({data_valid, stock_id} !== {1'b1, 2'd3}) begin
            n_fail++;
            $display("FAIL uncross_quote: got valid=%0b id=%0d, expected valid=1 id=3", data_valid, stock_id);
        end
        wait_drain(left);
        n_checks++;
        if (left != 0) begin
            n_fail++;
            $display("FAIL crossed_drain: got %0d quotes outstanding, expected 0", left);
        end
    endtask

    task automatic test_back_to_back();
        int left;
        exp_q.push_back(mkq(2'd1, 32'd100, 32'd120));
        exp_q.push_back(mkq(2'd1, 32'd110, 32'd120));
        book(2'd1, 1'b0, 32'd100);
        book(2'd1, 1'b1, 32'd120);
        book(2'd1, 1'b0, 32'd110);
        wait_drain(left);
        n_checks++;
        if (left != 0) begin
            n_fail++;
            $display("FAIL set_wins_drain: got %0d quotes outstanding, expected 0", left);
        end
    endtask

    task automatic test_reset_midstall();
        ready = 1'b0;
        exp_q.push_back(mkq(2'd2, 32'd5, 32'd6));
        book(2'd2, 1'b0, 32'd5);
        book(2'd2, 1'b1, 32'd6);
        tick();
        n_checks++;
        if ({data_valid, crossed_count} !== {1'b1, 16'd1}) begin
            n_fail++;
            $display("FAIL pre_reset: got valid=%0b cnt=%0d, expected valid=1 cnt=1", data_valid, crossed_count);
        end
        do_reset();
        n_checks++;
        if ({data_valid, crossed_count} !== {1'b0, 16'd0}) begin
            n_fail++;
            $display("FAIL reset_drop: got valid=%0b cnt=%0d, expected valid=0 cnt=0", data_valid, crossed_count);
        end
        ready = 1'b1;
        book(2'd2, 1'b0, 32'd7);
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (data_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_quiet: got valid=%0b, expected 0", data_valid);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        book_valid = 1'b0;
        book_id    = '0;
        book_side  = 1'b0;
        book_price = '0;
        ready      = 1'b1;
        tick();
        test_reset();
        test_latency();
        test_round_robin();
        test_stall();
        test_crossed();
        test_back_to_back();
        test_reset_midstall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
